// File: rtl/toy_run_sequencer_if.sv
//------------------------------------------------------------------------------
// Module      : toy_run_sequencer_if
// Description : Command, kernel ap_ctrl_hs/RAM, host access and RAM port bundle
//               for toy_run_sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface toy_run_sequencer_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
);
    logic              cmd_start;
    logic [CNT_W-1:0]  cmd_runs;
    logic              cmd_abort;
    logic              cmd_busy;
    logic              cmd_done;
    logic              cmd_aborted;
    logic [CNT_W-1:0]  runs_done;

    logic              k_ap_start;
    logic              k_ap_done;
    logic              k_ap_ready;
    logic [ADDR_W-1:0] k_c_address0;
    logic              k_c_ce0;
    logic              k_c_we0;
    logic [DATA_W-1:0] k_c_d0;
    logic [DATA_W-1:0] k_c_q0;

    logic              h_req;
    logic              h_we;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic              h_gnt;
    logic              h_rvalid;
    logic [DATA_W-1:0] h_rdata;

    logic [ADDR_W-1:0] m_address0;
    logic              m_ce0;
    logic              m_we0;
    logic [DATA_W-1:0] m_d0;
    logic [DATA_W-1:0] m_q0;

    // Sequencer view
    modport slave (
        input  cmd_start, cmd_runs, cmd_abort,
        output cmd_busy, cmd_done, cmd_aborted, runs_done,
        output k_ap_start,
        input  k_ap_done, k_ap_ready,
        input  k_c_address0, k_c_ce0, k_c_we0, k_c_d0,
        output k_c_q0,
        input  h_req, h_we, h_addr, h_wdata,
        output h_gnt, h_rvalid, h_rdata,
        output m_address0, m_ce0, m_we0, m_d0,
        input  m_q0
    );

    // Environment view: host, kernel and RAM
    modport master (
        output cmd_start, cmd_runs, cmd_abort,
        input  cmd_busy, cmd_done, cmd_aborted, runs_done,
        input  k_ap_start,
        output k_ap_done, k_ap_ready,
        output k_c_address0, k_c_ce0, k_c_we0, k_c_d0,
        input  k_c_q0,
        output h_req, h_we, h_addr, h_wdata,
        input  h_gnt, h_rvalid, h_rdata,
        input  m_address0, m_ce0, m_we0, m_d0,
        output m_q0
    );
endinterface

`default_nettype wire

// File: rtl/toy_run_sequencer.sv
//------------------------------------------------------------------------------
// Module      : toy_run_sequencer
// Description : Launches the toy kernel a programmable number of times and
//               arbitrates RAM c between the kernel (priority) and the host.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module toy_run_sequencer #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  wire logic            ap_clk,
    input  wire logic            ap_rst_n,
    toy_run_sequencer_if.slave   bus
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;
    localparam logic [1:0] c_ST_FIN  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_target;
    logic [CNT_W-1:0]  r_runs_done;
    logic              r_abort_pend;
    logic              r_aborted;
    logic              r_h_rvalid;

    logic              w_run_done;
    logic [CNT_W-1:0]  w_runs_inc;
    logic              w_abort_any;
    logic              w_last_run;
    logic              w_fin_by_abort;

    logic              w_k_ap_start;
    logic              w_cmd_busy;
    logic              w_cmd_done;

    logic              w_h_gnt;
    logic [ADDR_W-1:0] w_m_address;
    logic              w_m_ce;
    logic              w_m_we;
    logic [DATA_W-1:0] w_m_d;

    assign w_run_done  = (r_state == c_ST_RUN) & bus.k_ap_done & bus.k_ap_ready;
    assign w_runs_inc  = r_runs_done + CNT_W'(1);
    // An abort arriving in the very cycle the run completes still counts
    assign w_abort_any = r_abort_pend | bus.cmd_abort;
    assign w_last_run  = (w_runs_inc == r_target);
    assign w_fin_by_abort = (w_run_done & w_abort_any)
                          | ((r_state == c_ST_GAP) & bus.cmd_abort);

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.cmd_start) begin
                    w_state_nxt = (bus.cmd_runs != '0) ? c_ST_RUN : c_ST_FIN;
                end
            end
            c_ST_RUN: begin
                if (w_run_done) begin
                    w_state_nxt = (w_last_run || w_abort_any) ? c_ST_FIN : c_ST_GAP;
                end
            end
            c_ST_GAP: w_state_nxt = bus.cmd_abort ? c_ST_FIN : c_ST_RUN;
            c_ST_FIN: w_state_nxt = c_ST_IDLE;
            default:  w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_k_ap_start = 1'b0;
        w_cmd_busy   = 1'b0;
        w_cmd_done   = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                w_k_ap_start = 1'b1;
                w_cmd_busy   = 1'b1;
            end
            c_ST_GAP: w_cmd_busy = 1'b1;
            c_ST_FIN: w_cmd_done = 1'b1;
            default: ;
        endcase
    end

    // Batch bookkeeping and host read-valid pipeline
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_target     <= '0;
            r_runs_done  <= '0;
            r_abort_pend <= 1'b0;
            r_aborted    <= 1'b0;
            r_h_rvalid   <= 1'b0;
        end else begin
            r_h_rvalid <= w_h_gnt & ~bus.h_we;
            if ((r_state == c_ST_IDLE) && bus.cmd_start) begin
                r_target     <= bus.cmd_runs;
                r_runs_done  <= '0;
                r_aborted    <= 1'b0;
                r_abort_pend <= 1'b0;
            end
            if ((r_state == c_ST_RUN) && bus.cmd_abort) begin
                r_abort_pend <= 1'b1;
            end
            if (w_run_done) begin
                r_runs_done <= w_runs_inc;
            end
            if (w_fin_by_abort) begin
                r_aborted <= 1'b1;
            end
            if (r_state == c_ST_FIN) begin
                r_abort_pend <= 1'b0;
            end
        end
    end

    // RAM arbitration: the kernel always wins a cycle in which it enables c
    always_comb begin
        w_h_gnt     = 1'b0;
        w_m_address = bus.h_addr;
        w_m_ce      = bus.h_req;
        w_m_we      = bus.h_req & bus.h_we;
        w_m_d       = bus.h_wdata;
        if (bus.k_c_ce0) begin
            w_m_address = bus.k_c_address0;
            w_m_ce      = 1'b1;
            w_m_we      = bus.k_c_we0;
            w_m_d       = bus.k_c_d0;
        end else begin
            w_h_gnt     = bus.h_req;
        end
    end

    assign bus.k_ap_start  = w_k_ap_start;
    assign bus.cmd_busy    = w_cmd_busy;
    assign bus.cmd_done    = w_cmd_done;
    assign bus.cmd_aborted = r_aborted;
    assign bus.runs_done   = r_runs_done;

    assign bus.m_address0  = w_m_address;
    assign bus.m_ce0       = w_m_ce;
    assign bus.m_we0       = w_m_we;
    assign bus.m_d0        = w_m_d;
    assign bus.k_c_q0      = bus.m_q0;

    assign bus.h_gnt       = w_h_gnt;
    assign bus.h_rvalid    = r_h_rvalid;
    assign bus.h_rdata     = bus.m_q0;

endmodule

`default_nettype wire

// File: tb/tb_toy_run_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_toy_run_sequencer
// Description : Directed self-checking bench with a kernel model and RAM model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_toy_run_sequencer;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;
    int   checks   = 0;
    int   errors   = 0;
    int   k_lat    = 200;
    bit   k_mem    = 1'b0;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ram_q;

    toy_run_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    toy_run_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    always #5 ap_clk = ~ap_clk;

    // Single-port RAM c, one-cycle read latency
    assign bus.m_q0 = ram_q;
    always @(posedge ap_clk) begin
        if (bus.m_ce0) begin
            if (bus.m_we0) mem[bus.m_address0] <= bus.m_d0;
            else           ram_q <= mem[bus.m_address0];
        end
    end

    // Kernel model: done/ready k_lat cycles after start; optional RAM traffic
    initial begin : kernel_model
        bit kbusy;
        int kcnt;
        kbusy = 1'b0;
        kcnt  = 0;
        bus.k_ap_done = 1'b0; bus.k_ap_ready = 1'b0;
        bus.k_c_ce0 = 1'b0; bus.k_c_we0 = 1'b0;
        bus.k_c_address0 = '0; bus.k_c_d0 = '0;
        forever begin
            @(posedge ap_clk);
            #1;
            bus.k_ap_done = 1'b0; bus.k_ap_ready = 1'b0;
            bus.k_c_ce0 = 1'b0;   bus.k_c_we0 = 1'b0;
            if (!ap_rst_n) begin
                kbusy = 1'b0;
            end else if (kbusy) begin
                kcnt++;
                if (kcnt == k_lat) begin
                    bus.k_ap_done = 1'b1; bus.k_ap_ready = 1'b1;
                    kbusy = 1'b0;
                    if (k_mem) begin
                        bus.k_c_ce0 = 1'b1; bus.k_c_we0 = 1'b1;
                        bus.k_c_address0 = 7'd7; bus.k_c_d0 = 32'h1234_5678;
                    end
                end else if (k_mem) begin
                    bus.k_c_ce0 = 1'b1; bus.k_c_address0 = 7'd0;
                end
            end else if (bus.k_ap_start) begin
                kbusy = 1'b1;
                kcnt  = 0;
                if (k_mem) begin
                    bus.k_c_ce0 = 1'b1; bus.k_c_address0 = 7'd0;
                end
            end
        end
    end

    task automatic pulse_start(input logic [CNT_W-1:0] runs);
        @(negedge ap_clk);
        bus.cmd_start = 1'b1;
        bus.cmd_runs  = runs;
        @(negedge ap_clk);
        bus.cmd_start = 1'b0;
    endtask

    task automatic test_reset;
        ap_rst_n = 1'b0;
        #3;
        checks++; if (bus.k_ap_start !== 1'b0) begin errors++; $display("FAIL reset_k_ap_start: got %0b expected 0", bus.k_ap_start); end
        checks++; if (bus.cmd_busy !== 1'b0) begin errors++; $display("FAIL reset_cmd_busy: got %0b expected 0", bus.cmd_busy); end
        checks++; if (bus.cmd_done !== 1'b0) begin errors++; $display("FAIL reset_cmd_done: got %0b expected 0", bus.cmd_done); end
        checks++; if (bus.cmd_aborted !== 1'b0) begin errors++; $display("FAIL reset_cmd_aborted: got %0b expected 0", bus.cmd_aborted); end
        checks++; if (bus.h_rvalid !== 1'b0) begin errors++; $display("FAIL reset_h_rvalid: got %0b expected 0", bus.h_rvalid); end
        checks++; if (bus.runs_done !== 8'd0) begin errors++; $display("FAIL reset_runs_done: got %0d expected 0", bus.runs_done); end
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        checks++; if (bus.cmd_busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy got %0b expected 0", bus.cmd_busy); end
    endtask

    task automatic test_three_runs;
        int starts = 0, dones = 0, gap_len = 0, since_done = 0;
        bit prev_start = 1'b0, fin = 1'b0;
        logic [CNT_W-1:0] prev_rd = '0;
        k_lat = 200; k_mem = 1'b0;
        pulse_start(8'd3);
        for (int i = 0; i < 1000 && !fin; i++) begin
            if (i > 0) @(negedge ap_clk);
            since_done++;
            if (bus.k_ap_start && !prev_start) begin
                if (starts > 0) begin
                    checks++; if (gap_len !== 1) begin errors++; $display("FAIL three_gap_len: got %0d expected 1", gap_len); end
                end
                starts++;
                gap_len = 0;
            end
            if (!bus.k_ap_start && starts > 0) gap_len++;
            if (bus.runs_done !== prev_rd) begin
                checks++; if (bus.runs_done !== prev_rd + 8'd1) begin errors++; $display("FAIL three_runs_step: got %0d expected %0d", bus.runs_done, prev_rd + 8'd1); end
                prev_rd = bus.runs_done;
            end
            if (bus.cmd_done) begin
                fin = 1'b1;
                checks++; if (since_done !== 1) begin errors++; $display("FAIL three_done_latency: got %0d expected 1", since_done); end
                checks++; if (dones !== 3) begin errors++; $display("FAIL three_kernel_dones: got %0d expected 3", dones); end
                checks++; if (starts !== 3) begin errors++; $display("FAIL three_starts: got %0d expected 3", starts); end
                checks++; if (bus.runs_done !== 8'd3) begin errors++; $display("FAIL three_runs_done: got %0d expected 3", bus.runs_done); end
                checks++; if (bus.cmd_busy !== 1'b0) begin errors++; $display("FAIL three_busy_at_done: got %0b expected 0", bus.cmd_busy); end
                checks++; if (bus.cmd_aborted !== 1'b0) begin errors++; $display("FAIL three_aborted: got %0b expected 0", bus.cmd_aborted); end
            end
            if (bus.k_ap_done && bus.k_ap_ready) begin
                dones++;
                since_done = 0;
            end
            prev_start = bus.k_ap_start;
        end
        checks++; if (!fin) begin errors++; $display("FAIL three_timeout: got no cmd_done expected cmd_done"); end
        @(negedge ap_clk);
        checks++; if ({bus.cmd_done, bus.cmd_busy, bus.k_ap_start} !== 3'b000) begin errors++; $display("FAIL three_after: got %03b expected 000", {bus.cmd_done, bus.cmd_busy, bus.k_ap_start}); end
    endtask

    task automatic test_zero_runs;
        pulse_start(8'd0);
        checks++; if (bus.cmd_done !== 1'b1) begin errors++; $display("FAIL zero_cmd_done: got %0b expected 1", bus.cmd_done); end
        checks++; if (bus.k_ap_start !== 1'b0) begin errors++; $display("FAIL zero_k_ap_start: got %0b expected 0", bus.k_ap_start); end
        checks++; if (bus.runs_done !== 8'd0) begin errors++; $display("FAIL zero_runs_done: got %0d expected 0", bus.runs_done); end
        checks++; if (bus.cmd_busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %0b expected 0", bus.cmd_busy); end
        @(negedge ap_clk);
        checks++; if ({bus.cmd_done, bus.k_ap_start} !== 2'b00) begin errors++; $display("FAIL zero_after: got %02b expected 00", {bus.cmd_done, bus.k_ap_start}); end
    endtask

    task automatic test_host_rw;
        @(negedge ap_clk);
        bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = 7'd5; bus.h_wdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (bus.h_gnt !== 1'b1) begin errors++; $display("FAIL hw_gnt: got %0b expected 1", bus.h_gnt); end
        checks++; if ({bus.m_ce0, bus.m_we0} !== 2'b11) begin errors++; $display("FAIL hw_ce_we: got %02b expected 11", {bus.m_ce0, bus.m_we0}); end
        checks++; if (bus.m_d0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hw_d0: got %08h expected deadbeef", bus.m_d0); end
        checks++; if (bus.m_address0 !== 7'd5) begin errors++; $display("FAIL hw_addr: got %0d expected 5", bus.m_address0); end
        @(negedge ap_clk);
        bus.h_we = 1'b0;
        #1;
        checks++; if (bus.h_gnt !== 1'b1) begin errors++; $display("FAIL hr_gnt: got %0b expected 1", bus.h_gnt); end
        checks++; if ({bus.m_ce0, bus.m_we0} !== 2'b10) begin errors++; $display("FAIL hr_ce_we: got %02b expected 10", {bus.m_ce0, bus.m_we0}); end
        checks++; if (bus.h_rvalid !== 1'b0) begin errors++; $display("FAIL hr_rvalid_after_write: got %0b expected 0", bus.h_rvalid); end
        @(negedge ap_clk);
        checks++; if (bus.h_rvalid !== 1'b1) begin errors++; $display("FAIL hr_rvalid1: got %0b expected 1", bus.h_rvalid); end
        checks++; if (bus.h_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hr_rdata1: got %08h expected deadbeef", bus.h_rdata); end
        @(negedge ap_clk);
        bus.h_req = 1'b0;
        checks++; if (bus.h_rvalid !== 1'b1) begin errors++; $display("FAIL hr_rvalid2: got %0b expected 1", bus.h_rvalid); end
        checks++; if (bus.h_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hr_rdata2: got %08h expected deadbeef", bus.h_rdata); end
        @(negedge ap_clk);
        checks++; if (bus.h_rvalid !== 1'b0) begin errors++; $display("FAIL hr_rvalid_end: got %0b expected 0", bus.h_rvalid); end
    endtask

    task automatic test_host_wait;
        bit seen = 1'b0, granted = 1'b0, fin = 1'b0;
        k_lat = 10; k_mem = 1'b1;
        pulse_start(8'd2);
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge ap_clk);
            if (bus.k_c_ce0) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL wait_kernel_ce: got 0 expected 1"); end
        bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 7'd7;
        for (int i = 0; i < 100 && !granted; i++) begin
            @(negedge ap_clk);
            #1;
            checks++; if (bus.h_gnt !== ~bus.k_c_ce0) begin errors++; $display("FAIL wait_gnt_vs_ce: got %0b expected %0b", bus.h_gnt, ~bus.k_c_ce0); end
            if (bus.k_c_ce0) begin
                checks++; if ({bus.m_we0, bus.m_address0} !== {bus.k_c_we0, bus.k_c_address0}) begin errors++; $display("FAIL wait_kernel_path: got %0h expected %0h", {bus.m_we0, bus.m_address0}, {bus.k_c_we0, bus.k_c_address0}); end
            end
            if (bus.h_gnt) begin
                granted = 1'b1;
                checks++; if ({bus.k_ap_start, bus.cmd_busy} !== 2'b01) begin errors++; $display("FAIL wait_gnt_in_gap: got %02b expected 01", {bus.k_ap_start, bus.cmd_busy}); end
            end
        end
        checks++; if (!granted) begin errors++; $display("FAIL wait_gnt_timeout: got 0 expected 1"); end
        @(negedge ap_clk);
        bus.h_req = 1'b0;
        checks++; if (bus.h_rvalid !== 1'b1) begin errors++; $display("FAIL wait_rvalid: got %0b expected 1", bus.h_rvalid); end
        checks++; if (bus.h_rdata !== 32'h1234_5678) begin errors++; $display("FAIL wait_rdata: got %08h expected 12345678", bus.h_rdata); end
        for (int i = 0; i < 200 && !fin; i++) begin
            @(negedge ap_clk);
            if (bus.cmd_done) begin
                fin = 1'b1;
                checks++; if (bus.runs_done !== 8'd2) begin errors++; $display("FAIL wait_runs_done: got %0d expected 2", bus.runs_done); end
            end
        end
        checks++; if (!fin) begin errors++; $display("FAIL wait_done_timeout: got 0 expected 1"); end
        k_mem = 1'b0;
    endtask

    task automatic test_abort;
        int starts = 0, dones = 0, run2 = 0, late_starts = 0;
        bit prev_start = 1'b0, fin = 1'b0, sent = 1'b0;
        k_lat = 20;
        pulse_start(8'd5);
        for (int i = 0; i < 1000 && !fin; i++) begin
            if (i > 0) @(negedge ap_clk);
            bus.cmd_abort = 1'b0;
            if (bus.k_ap_start && !prev_start) starts++;
            if (dones == 1 && bus.k_ap_start && !sent) begin
                run2++;
                if (run2 == 5) begin bus.cmd_abort = 1'b1; sent = 1'b1; end
            end
            if (bus.cmd_done) begin
                fin = 1'b1;
                checks++; if (bus.runs_done !== 8'd2) begin errors++; $display("FAIL abort_runs_done: got %0d expected 2", bus.runs_done); end
                checks++; if (bus.cmd_aborted !== 1'b1) begin errors++; $display("FAIL abort_flag: got %0b expected 1", bus.cmd_aborted); end
                checks++; if (starts !== 2) begin errors++; $display("FAIL abort_starts: got %0d expected 2", starts); end
            end
            if (bus.k_ap_done && bus.k_ap_ready) dones++;
            prev_start = bus.k_ap_start;
        end
        bus.cmd_abort = 1'b0;
        checks++; if (!fin) begin errors++; $display("FAIL abort_timeout: got 0 expected 1"); end
        for (int i = 0; i < 30; i++) begin
            @(negedge ap_clk);
            if (bus.k_ap_start) late_starts++;
        end
        checks++; if (late_starts !== 0) begin errors++; $display("FAIL abort_no_third_start: got %0d expected 0", late_starts); end
        checks++; if (bus.cmd_aborted !== 1'b1) begin errors++; $display("FAIL abort_flag_hold: got %0b expected 1", bus.cmd_aborted); end
        pulse_start(8'd0);
        checks++; if (bus.cmd_aborted !== 1'b0) begin errors++; $display("FAIL abort_clear_on_start: got %0b expected 0", bus.cmd_aborted); end
    endtask

    task automatic test_reset_mid_run;
        bit seen = 1'b0, fin = 1'b0;
        k_lat = 50;
        pulse_start(8'd3);
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge ap_clk);
            if (bus.runs_done == 8'd1) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL rst_first_run: got 0 expected 1"); end
        @(negedge ap_clk);
        @(negedge ap_clk);
        bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 7'd5;
        @(posedge ap_clk);
        #2;
        checks++; if ({bus.h_rvalid, bus.k_ap_start, bus.cmd_busy} !== 3'b111) begin errors++; $display("FAIL rst_pre: got %03b expected 111", {bus.h_rvalid, bus.k_ap_start, bus.cmd_busy}); end
        ap_rst_n = 1'b0;
        bus.h_req = 1'b0;
        #1;
        checks++; if (bus.k_ap_start !== 1'b0) begin errors++; $display("FAIL rst_async_start: got %0b expected 0", bus.k_ap_start); end
        checks++; if (bus.cmd_busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %0b expected 0", bus.cmd_busy); end
        checks++; if (bus.h_rvalid !== 1'b0) begin errors++; $display("FAIL rst_async_rvalid: got %0b expected 0", bus.h_rvalid); end
        checks++; if (bus.runs_done !== 8'd0) begin errors++; $display("FAIL rst_async_runs: got %0d expected 0", bus.runs_done); end
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ap_clk);
            checks++; if ({bus.cmd_busy, bus.k_ap_start, bus.cmd_done} !== 3'b000 || bus.runs_done !== 8'd0) begin errors++; $display("FAIL rst_idle: got %03b/%0d expected 000/0", {bus.cmd_busy, bus.k_ap_start, bus.cmd_done}, bus.runs_done); end
        end
        k_lat = 5;
        pulse_start(8'd1);
        for (int i = 0; i < 100 && !fin; i++) begin
            @(negedge ap_clk);
            if (bus.cmd_done) begin
                fin = 1'b1;
                checks++; if (bus.runs_done !== 8'd1) begin errors++; $display("FAIL rst_rerun_runs: got %0d expected 1", bus.runs_done); end
            end
        end
        checks++; if (!fin) begin errors++; $display("FAIL rst_rerun_timeout: got 0 expected 1"); end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bus.cmd_start = 1'b0; bus.cmd_runs = '0; bus.cmd_abort = 1'b0;
        bus.h_req = 1'b0; bus.h_we = 1'b0; bus.h_addr = '0; bus.h_wdata = '0;
        test_reset;
        test_three_runs;
        test_zero_runs;
        test_host_rw;
        test_host_wait;
        test_abort;
        test_reset_mid_run;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
